// File: rtl/trigger_pkg.sv
// Shared types and constants for the trigger conditioner: FSM states,
// trig_src encodings and per-source bit positions.
`default_nettype none

package trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_FIRE    = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_EXT  = 2'd1;
  localparam logic [1:0] SRC_MCU  = 2'd2;
  localparam logic [1:0] SRC_PTP  = 2'd3;

  localparam int NUM_SRC = 3;
  localparam int IDX_EXT = 0;
  localparam int IDX_MCU = 1;
  localparam int IDX_PTP = 2;

  function automatic logic [1:0] popcount3(input logic [NUM_SRC-1:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trigger_debounce.sv
// Per-source synchroniser, stability filter and qualified-edge detector.
// The edge flags are registered together with the filtered level.
`default_nettype none

module trigger_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  input  logic en_i,
  input  logic edge_sel_i,
  output logic qual_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          stab_q, stab_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Counter only runs while the synchronised level disagrees with the filter;
  // agreement (a reversion) clears it.
  always_comb begin
    stab_d = '0;
    filt_d = filt_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_lvl != filt_q) begin
      if (stab_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync_lvl;
        rise_d = sync_lvl;
        fall_d = ~sync_lvl;
      end else begin
        stab_d = stab_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      stab_q <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      filt_q <= filt_d;
      stab_q <= stab_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign qual_o = en_i & (edge_sel_i ? fall_q : rise_q);

endmodule

`default_nettype wire

// File: rtl/trigger_conditioner.sv
// Three-source trigger conditioner: debounced edge qualification, arm/fire/
// holdoff sequencing, fire timestamping and missed-edge accounting.
`default_nettype none

module trigger_conditioner
  import trigger_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_trigger_in,
  input  logic             mcu_trigger_in,
  input  logic             ptp_trigger_in,
  input  logic [2:0]       cfg_src_en,
  input  logic [2:0]       cfg_edge,
  input  logic             cfg_rearm,
  input  logic [15:0]      cfg_holdoff,
  input  logic             arm,
  input  logic             disarm,
  output logic             trig_out,
  output logic [1:0]       trig_src,
  output logic [CNT_W-1:0] trig_timestamp,
  output logic [CNT_W-1:0] trig_count,
  output logic [15:0]      missed_count,
  output logic             armed,
  output logic             busy
);

  logic [NUM_SRC-1:0] trig_raw;
  logic [NUM_SRC-1:0] qual;

  assign trig_raw[IDX_EXT] = ext_trigger_in;
  assign trig_raw[IDX_MCU] = mcu_trigger_in;
  assign trig_raw[IDX_PTP] = ptp_trigger_in;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    trigger_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .rst       (rst),
      .async_i   (trig_raw[i]),
      .en_i      (cfg_src_en[i]),
      .edge_sel_i(cfg_edge[i]),
      .qual_o    (qual[i])
    );
  end

  state_e           state_q, state_d;
  logic [15:0]      ho_q, ho_d;
  logic [CNT_W-1:0] ts_q;
  logic [1:0]       src_q, src_d;
  logic [CNT_W-1:0] tstamp_q;
  logic [CNT_W-1:0] count_q;
  logic [15:0]      missed_q, missed_d;
  logic             fire;
  logic [1:0]       n_qual;
  logic [1:0]       miss_add;
  logic [16:0]      miss_sum;

  assign n_qual = popcount3(qual);

  always_comb begin
    if (qual[IDX_PTP])      src_d = SRC_PTP;
    else if (qual[IDX_EXT]) src_d = SRC_EXT;
    else                    src_d = SRC_MCU;
  end

  always_comb begin
    state_d = state_q;
    ho_d    = ho_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (|qual) begin
          state_d = ST_FIRE;
          ho_d    = cfg_holdoff;
          fire    = 1'b1;
        end
      end
      ST_FIRE: begin
        if (ho_q == 16'd0) state_d = cfg_rearm ? ST_ARMED : ST_IDLE;
        else               state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (ho_q <= 16'd1) state_d = cfg_rearm ? ST_ARMED : ST_IDLE;
        else               ho_d    = ho_q - 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (disarm) begin
      state_d = ST_IDLE;
      fire    = 1'b0;
    end
  end

  // Only the winning edge of an accepted fire is not counted as missed.
  always_comb begin
    miss_add = n_qual;
    if (state_q == ST_ARMED && !disarm && n_qual != 2'd0) miss_add = n_qual - 2'd1;
    miss_sum = {1'b0, missed_q} + 17'(miss_add);
    missed_d = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ho_q     <= '0;
      ts_q     <= '0;
      src_q    <= SRC_NONE;
      tstamp_q <= '0;
      count_q  <= '0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      ho_q     <= ho_d;
      ts_q     <= ts_q + CNT_W'(1);
      missed_q <= missed_d;
      if (fire) begin
        src_q    <= src_d;
        tstamp_q <= ts_q;
        count_q  <= count_q + CNT_W'(1);
      end
    end
  end

  assign trig_out       = (state_q == ST_FIRE);
  assign armed          = (state_q == ST_ARMED);
  assign busy           = (state_q == ST_FIRE) || (state_q == ST_HOLDOFF);
  assign trig_src       = src_q;
  assign trig_timestamp = tstamp_q;
  assign trig_count     = count_q;
  assign missed_count   = missed_q;

endmodule

`default_nettype wire

// File: tb/tb_trigger_conditioner.sv
// Scoreboard bench: stimulus pushes expected fires, a negedge monitor pops them
// whenever trig_out is seen.
`default_nettype none

module tb_trigger_conditioner;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_W           = 32;
  localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

  logic             clk = 1'b0;
  logic             rst;
  logic             ext_in, mcu_in, ptp_in;
  logic [2:0]       cfg_src_en, cfg_edge;
  logic             cfg_rearm;
  logic [15:0]      cfg_holdoff;
  logic             arm, disarm;
  logic             trig_out;
  logic [1:0]       trig_src;
  logic [CNT_W-1:0] trig_timestamp, trig_count;
  logic [15:0]      missed_count;
  logic             armed, busy;

  trigger_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_trigger_in(ext_in),
    .mcu_trigger_in(mcu_in),
    .ptp_trigger_in(ptp_in),
    .cfg_src_en    (cfg_src_en),
    .cfg_edge      (cfg_edge),
    .cfg_rearm     (cfg_rearm),
    .cfg_holdoff   (cfg_holdoff),
    .arm           (arm),
    .disarm        (disarm),
    .trig_out      (trig_out),
    .trig_src      (trig_src),
    .trig_timestamp(trig_timestamp),
    .trig_count    (trig_count),
    .missed_count  (missed_count),
    .armed         (armed),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       src;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ts;
  } exp_t;

  exp_t             exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] m_ts;

  // Reference model of the free-running timestamp counter.
  always @(posedge clk) begin
    if (rst) m_ts <= '0;
    else     m_ts <= m_ts + CNT_W'(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_fire(input logic [1:0] src, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.src = src;
    e.cnt = cnt;
    e.ts  = m_ts + CNT_W'(LAT);
    exp_q.push_back(e);
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("fire_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Monitor: every trig_out cycle must match the oldest expected fire.
  always @(negedge clk) begin
    if (trig_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fire", 64'd1, 64'd0);
      end else begin
        exp_t e;
        logic [CNT_W-1:0] d;
        e = exp_q.pop_front();
        chk("fire_src", 64'(trig_src), 64'(e.src));
        chk("fire_count", 64'(trig_count), 64'(e.cnt));
        d = trig_timestamp - e.ts;
        checks++;
        if (d > CNT_W'(1)) begin
          failures++;
          $display("FAIL fire_timestamp actual=%0h required=%0h..%0h",
                   trig_timestamp, e.ts, e.ts + CNT_W'(1));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ext_in = 0; mcu_in = 0; ptp_in = 0;
    cfg_src_en = 3'b001; cfg_edge = 3'b000; cfg_rearm = 1'b1; cfg_holdoff = 16'd5;
    arm = 0; disarm = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;

    chk("rst_trig_out", 64'(trig_out), 0);
    chk("rst_armed", 64'(armed), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_src", 64'(trig_src), 0);
    chk("rst_ts", 64'(trig_timestamp), 0);
    chk("rst_count", 64'(trig_count), 0);
    chk("rst_missed", 64'(missed_count), 0);

    // Single EXT rising edge
    pulse_arm();
    chk("armed_after_arm", 64'(armed), 1);
    push_fire(2'd1, CNT_W'(1));
    ext_in = 1'b1;
    repeat (10) @(negedge clk);
    ext_in = 1'b0;
    wait_empty(20);
    repeat (12) @(negedge clk);
    chk("ext_rearmed", 64'(armed), 1);
    chk("ext_missed", 64'(missed_count), 0);

    // Short glitch must be filtered out
    ext_in = 1'b1;
    repeat (3) @(negedge clk);
    ext_in = 1'b0;
    repeat (15) @(negedge clk);
    chk("glitch_missed", 64'(missed_count), 0);
    chk("glitch_count", 64'(trig_count), 1);

    // Simultaneous EXT and PTP: PTP wins, EXT is missed
    cfg_src_en = 3'b101;
    push_fire(2'd3, CNT_W'(2));
    ext_in = 1'b1; ptp_in = 1'b1;
    wait_empty(20);
    chk("simul_missed", 64'(missed_count), 1);
    repeat (10) @(negedge clk);
    ext_in = 1'b0; ptp_in = 1'b0;
    repeat (12) @(negedge clk);

    // Holdoff 20: second MCU edge 10 cycles later lands in holdoff
    cfg_src_en = 3'b010; cfg_holdoff = 16'd20;
    push_fire(2'd2, CNT_W'(3));
    mcu_in = 1'b1;
    repeat (5) @(negedge clk);
    mcu_in = 1'b0;
    repeat (5) @(negedge clk);
    mcu_in = 1'b1;
    repeat (5) @(negedge clk);
    mcu_in = 1'b0;
    repeat (15) @(negedge clk);
    push_fire(2'd2, CNT_W'(4));
    mcu_in = 1'b1;
    repeat (5) @(negedge clk);
    mcu_in = 1'b0;
    wait_empty(20);
    chk("holdoff_missed", 64'(missed_count), 2);
    repeat (25) @(negedge clk);

    // Disarm during holdoff
    push_fire(2'd2, CNT_W'(5));
    mcu_in = 1'b1;
    wait_empty(20);
    repeat (3) @(negedge clk);
    chk("holdoff_busy", 64'(busy), 1);
    disarm = 1'b1;
    @(negedge clk);
    disarm = 1'b0;
    chk("disarm_armed", 64'(armed), 0);
    chk("disarm_busy", 64'(busy), 0);
    mcu_in = 1'b0;
    repeat (10) @(negedge clk);
    mcu_in = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_missed", 64'(missed_count), 3);
    chk("idle_count", 64'(trig_count), 5);
    mcu_in = 1'b0;
    repeat (10) @(negedge clk);

    // Reset in the middle of holdoff
    pulse_arm();
    push_fire(2'd2, CNT_W'(6));
    mcu_in = 1'b1;
    wait_empty(20);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 1);
    rst = 1'b1; mcu_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst_trig_out", 64'(trig_out), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_armed", 64'(armed), 0);
    chk("mid_rst_src", 64'(trig_src), 0);
    chk("mid_rst_ts", 64'(trig_timestamp), 0);
    chk("mid_rst_count", 64'(trig_count), 0);
    chk("mid_rst_missed", 64'(missed_count), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("post_rst_missed", 64'(missed_count), 0);

    // Timestamp wrap through zero
    cfg_src_en = 3'b001; cfg_holdoff = 16'd0; cfg_rearm = 1'b0;
    pulse_arm();
    force dut.ts_q = {CNT_W{1'b1}} - CNT_W'(2);
    m_ts = {CNT_W{1'b1}} - CNT_W'(2);
    #1 release dut.ts_q;
    push_fire(2'd1, CNT_W'(1));
    ext_in = 1'b1;
    wait_empty(20);
    chk("wrap_ts_small", 64'(trig_timestamp < CNT_W'(16)), 1);
    repeat (3) @(negedge clk);
    chk("norearm_idle", 64'(armed), 0);
    ext_in = 1'b0;
    repeat (10) @(negedge clk);

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trigger_conditioner.md
TRIGGER_CONDITIONER -- requirements
Module: trigger_conditioner

Interface
- REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per trigger input (min 2).
- REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before the filtered level changes (min 1).
- REQ-003 SHALL have parameter CNT_W, default 32: timestamp and trigger counter width.
- REQ-004 SHALL have port clk, input, 1: single clock; all logic in this domain.
- REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-006 SHALL have port ext_trigger_in, input, 1: asynchronous external trigger (FPGA_EXT_TRIGGER).
- REQ-007 SHALL have port mcu_trigger_in, input, 1: asynchronous MCU trigger (FPGA_TRIGGER_EN).
- REQ-008 SHALL have port ptp_trigger_in, input, 1: asynchronous PHY PTP trigger (PTP_TRG_FPGA).
- REQ-009 SHALL have port cfg_src_en, input, 3: per-source enable; bit0 EXT, bit1 MCU, bit2 PTP.
- REQ-010 SHALL have port cfg_edge, input, 3: per-source edge select; 0 rising, 1 falling.
- REQ-011 SHALL have port cfg_rearm, input, 1: 1 returns to ARMED after holdoff; 0 returns to IDLE.
- REQ-012 SHALL have port cfg_holdoff, input, 16: holdoff length in clk cycles after each fire.
- REQ-013 SHALL have port arm, input, 1: single-cycle pulse that arms the block.
- REQ-014 SHALL have port disarm, input, 1: single-cycle pulse that forces IDLE.
- REQ-015 SHALL have port trig_out, output, 1: single-cycle trigger pulse to the acquisition logic.
- REQ-016 SHALL have port trig_src, output, 2: source of the last fire; 0 none, 1 EXT, 2 MCU, 3 PTP.
- REQ-017 SHALL have port trig_timestamp, output, CNT_W: free-running cycle counter value captured at the fire.
- REQ-018 SHALL have port trig_count, output, CNT_W: number of fires since reset; wraps.
- REQ-019 SHALL have port missed_count, output, 16: qualified edges rejected while not ARMED; saturates at 0xFFFF.
- REQ-020 SHALL have port armed, output, 1: high in ARMED state.
- REQ-021 SHALL have port busy, output, 1: high in FIRE or HOLDOFF.

Function
- REQ-022 SHALL synchronise each input through SYNC_STAGES flops.
- REQ-023 SHALL debounce each synchronised input: the filtered level takes the new value once the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the stability counter.
- REQ-024 SHALL generate a qualified edge for a source only on a filtered-level transition matching cfg_edge, and only when cfg_src_en is set for that source.
- REQ-025 SHALL implement FSM states IDLE, ARMED, FIRE and HOLDOFF.
- REQ-026 SHALL move IDLE->ARMED on arm.
- REQ-027 SHALL move ARMED->FIRE on any qualified edge.
- REQ-028 SHALL stay in FIRE for exactly one cycle, then go to HOLDOFF.
- REQ-029 SHALL leave HOLDOFF after cfg_holdoff cycles (0 means zero holdoff cycles) to ARMED if cfg_rearm, else IDLE.
- REQ-030 SHALL sample cfg_holdoff on entry to FIRE.
- REQ-031 SHALL return any state to IDLE on disarm, which wins over a simultaneous arm or qualified edge.
- REQ-032 SHALL assert trig_out for exactly the FIRE cycle.
- REQ-033 SHALL update trig_src, trig_timestamp and trig_count in the same cycle trig_out is high.
- REQ-034 SHALL, for simultaneous qualified edges, use priority PTP > EXT > MCU; the losing edges count as missed.
- REQ-035 SHALL increment missed_count by the number of qualified edges in any cycle where the state is not ARMED, or by the losers of REQ-034, saturating at 0xFFFF.
- REQ-036 SHALL run the free-running timestamp counter every cycle from reset and wrap modulo 2^CNT_W.
- REQ-037 SHALL give a latency from an async input edge (held stable) to trig_out of SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles, +1 cycle for sampling uncertainty.

Reset
- REQ-038 SHALL, on rst, force state IDLE and set trig_out, armed, busy, trig_src, trig_timestamp, trig_count, missed_count, the timestamp counter and the stability counters to 0.
- REQ-039 SHALL, on rst, load the sync flops and filtered levels with 0.
- REQ-040 SHALL abort any fire or holdoff in progress when rst is asserted, with no trig_out pulse afterwards.

Structure
- REQ-041 SHALL place in package trigger_pkg: the state enum, the trig_src encodings (SRC_NONE/EXT/MCU/PTP) and the source index constants.
- REQ-042 SHALL implement sync+debounce+edge in sub-module trigger_debounce, instantiated three times.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
- REQ-043 SHALL cover: arm, then EXT rising held 10 cycles, edge=0, en=001 -> exactly one trig_out 7-8 cycles after the edge; trig_src=1; trig_count=1.
- REQ-044 SHALL cover: EXT glitch high for 3 cycles -> no trig_out; missed_count unchanged.
- REQ-045 SHALL cover: EXT and PTP edges released in the same cycle, both enabled -> trig_src=3; missed_count=1.
- REQ-046 SHALL cover: cfg_holdoff=20, cfg_rearm=1, MCU edges 10 cycles apart -> second edge missed; third edge fires.
- REQ-047 SHALL cover: disarm in HOLDOFF -> IDLE next cycle; later edges increment missed_count only; rst mid-HOLDOFF -> all outputs 0.
- REQ-048 SHALL cover: the timestamp counter preset via force near 2^CNT_W-1 -> trig_timestamp wraps correctly through 0.
